fpu_cmd_sequencer: RTL and testbench
====================================

FPU_CMD_SEQUENCER -- requirements
Module: fpu_cmd_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter W, default `REG_SIZE (32), operand/result width.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_a in W, cmd_b in W, cmd_op in `OP_BITS: command push.
REQ-006 SHALL have ports fpu_start out 1, fpu_a out W, fpu_b out W, fpu_op out `OP_BITS: FPU issue side.
REQ-007 SHALL have ports fpu_res in W, fpu_ready in 1: FPU completion side.
REQ-008 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_data out W, rsp_op out `OP_BITS: result pop.
REQ-009 SHALL have port count out $clog2(DEPTH+1): FIFO occupancy.

Function
REQ-010 Push SHALL occur on an edge where cmd_valid && cmd_ready; cmd_ready SHALL equal !full (no full-bypass).
REQ-011 FIFO pointers SHALL wrap modulo DEPTH; same-edge push and pop SHALL leave count unchanged.
REQ-012 FSM states SHALL be IDLE, ISSUE, WAIT, HOLD.
REQ-013 IDLE -> ISSUE when count != 0; else stay IDLE.
REQ-014 ISSUE SHALL last exactly one cycle with fpu_start=1, then go to WAIT; fpu_start SHALL be 0 in every other state.
REQ-015 fpu_a/fpu_b/fpu_op SHALL drive the FIFO head, registered on IDLE->ISSUE, and stay stable through ISSUE and WAIT.
REQ-016 fpu_ready SHALL be sampled only in WAIT; it is ignored in IDLE, ISSUE and HOLD.
REQ-017 WAIT with fpu_ready=1 SHALL capture fpu_res into rsp_data and fpu_op into rsp_op, pop the head, set rsp_valid, and go to HOLD.
REQ-018 HOLD SHALL keep rsp_valid=1 and rsp_data/rsp_op stable until rsp_ready=1.
REQ-019 On rsp_ready in HOLD: clear rsp_valid; go to ISSUE if count after the pop and any same-edge push != 0, else IDLE.
REQ-020 Minimum latency: command pushed at edge N into an empty idle block SHALL see fpu_start high in cycle N+2.
REQ-021 Commands SHALL be issued strictly in order, one in flight at a time.

Reset
REQ-022 During rst: state=IDLE, pointers and count=0, fpu_start=0, fpu_a/fpu_b/fpu_op=0, rsp_valid=0, rsp_data=0, rsp_op=0.
REQ-023 cmd_ready SHALL read 1 in the first cycle after rst deasserts.
REQ-024 rst mid-operation (any state) SHALL discard buffered commands and the in-flight result; a late fpu_ready after reset SHALL be ignored (state IDLE).

Configuration
REQ-025 Macro FPU_SEQ_TAG_EN defined: ports cmd_tag in `FPU_TAG_BITS and rsp_tag out `FPU_TAG_BITS exist; the tag is stored per FIFO entry and emitted with its result (reset 0).
REQ-026 FPU_SEQ_TAG_EN undefined: no tag ports or tag storage; all other behaviour identical.

Structure
REQ-027 `REG_SIZE, `OP_BITS, `FPU_TAG_BITS (2) and the FSM state encodings SHALL live in the shared definitions header.
REQ-028 The FIFO SHALL be a sub-module fpu_cmd_fifo (push/pop/full/empty/count, head read); fpu_cmd_sequencer holds the FSM and the issue/result registers.

Verification
REQ-029 Use a bench FPU model that raises fpu_ready 5 cycles after fpu_start with res = a ^ b. Push (A=0x40800000, B=0x40400000) at edge 0 with rsp_ready=1 -> fpu_start high cycle 2 only; rsp_valid high cycle 8 with rsp_data=0x00C00000.
REQ-030 Push 4 commands back-to-back with rsp_ready=0 -> cmd_ready=0 once count=4; a fifth push is not accepted; count stays 4 until the first result is pushed back out; results come out in order.
REQ-031 Hold rsp_ready=0 for 10 cycles in HOLD -> rsp_valid stays 1, rsp_data stable, no second fpu_start; rsp_ready=1 with count=2 -> ISSUE next cycle.
REQ-032 Assert rst in WAIT, model then raises fpu_ready -> rsp_valid stays 0, count=0, cmd_ready=1.
REQ-033 Same-edge push and pop at count=2 -> count stays 2; pointer wrap after 9 consecutive commands -> data is intact.
REQ-034 FPU_SEQ_TAG_EN defined: push tags 3,1,2 -> rsp_tag sequence 3,1,2 aligned with the matching rsp_data.

Source files
------------

// File: rtl/fpu_cmd_sequencer_pkg.sv
// Shared definitions for the FPU command sequencer: operand/opcode/tag widths and FSM encoding.
// Optional per-command tag storage is enabled by defining FPU_SEQ_TAG_EN.
`ifndef FPU_CMD_SEQUENCER_DEFS
`define FPU_CMD_SEQUENCER_DEFS
`define REG_SIZE 32
`define OP_BITS 4
`define FPU_TAG_BITS 2
`endif

package fpu_cmd_sequencer_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } seq_state_t;
endpackage

// File: rtl/fpu_cmd_fifo.sv
// Command FIFO for the FPU sequencer: power-of-two ring buffer with combinational head read.
module fpu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DW-1:0]              din,
  input  logic                       pop,
  output logic [DW-1:0]              head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  // Pointers are exactly AW bits wide, so the increment wraps modulo DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/fpu_cmd_sequencer.sv
// Buffers FPU commands, issues them one at a time in order, and holds each result until popped.
// Define FPU_SEQ_TAG_EN to carry a per-command tag through to the response.
module fpu_cmd_sequencer
  import fpu_cmd_sequencer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = `REG_SIZE
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [W-1:0]               cmd_a,
  input  logic [W-1:0]               cmd_b,
  input  logic [`OP_BITS-1:0]        cmd_op,
`ifdef FPU_SEQ_TAG_EN
  input  logic [`FPU_TAG_BITS-1:0]   cmd_tag,
  output logic [`FPU_TAG_BITS-1:0]   rsp_tag,
`endif
  output logic                       fpu_start,
  output logic [W-1:0]               fpu_a,
  output logic [W-1:0]               fpu_b,
  output logic [`OP_BITS-1:0]        fpu_op,
  input  logic [W-1:0]               fpu_res,
  input  logic                       fpu_ready,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [W-1:0]               rsp_data,
  output logic [`OP_BITS-1:0]        rsp_op,
  output logic [$clog2(DEPTH+1)-1:0] count
);
`ifdef FPU_SEQ_TAG_EN
  localparam int TW = `FPU_TAG_BITS;
`else
  localparam int TW = 0;
`endif
  localparam int DW = 2*W + `OP_BITS + TW;

  seq_state_t    state, state_nx;
  logic          push, full, empty;
  logic          load_issue, capture, release_rsp;
  logic [DW-1:0] push_data, head, issue_src;

  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;

`ifdef FPU_SEQ_TAG_EN
  assign push_data = {cmd_tag, cmd_op, cmd_b, cmd_a};
`else
  assign push_data = {cmd_op, cmd_b, cmd_a};
`endif

  fpu_cmd_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_data),
    .pop   (capture),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Leaving HOLD with an empty FIFO and a same-edge push: the entry is not
  // readable yet, so the issue registers take it straight from the push port.
  assign issue_src = empty ? push_data : head;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    load_issue  = 1'b0;
    capture     = 1'b0;
    release_rsp = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        state_nx   = ISSUE;
        load_issue = 1'b1;
      end
      ISSUE: state_nx = WAIT;
      WAIT: if (fpu_ready) begin
        capture  = 1'b1;
        state_nx = HOLD;
      end
      HOLD: if (rsp_ready) begin
        release_rsp = 1'b1;
        if (!empty || push) begin
          state_nx   = ISSUE;
          load_issue = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign fpu_start = (state == ISSUE);

  always_ff @(posedge clk) begin
    if (rst) begin
      fpu_a     <= '0;
      fpu_b     <= '0;
      fpu_op    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_op    <= '0;
    end else begin
      if (load_issue) begin
        fpu_a  <= issue_src[W-1:0];
        fpu_b  <= issue_src[2*W-1:W];
        fpu_op <= issue_src[2*W +: `OP_BITS];
      end
      if (capture) begin
        rsp_valid <= 1'b1;
        rsp_data  <= fpu_res;
        rsp_op    <= fpu_op;
      end else if (release_rsp) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef FPU_SEQ_TAG_EN
  logic [TW-1:0] issue_tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_tag <= '0;
      rsp_tag   <= '0;
    end else begin
      if (load_issue) issue_tag <= issue_src[DW-1 -: TW];
      if (capture)    rsp_tag   <= issue_tag;
    end
  end
`endif
endmodule

// File: tb/tb_fpu_cmd_sequencer.sv
// Self-checking bench for fpu_cmd_sequencer: an XOR FPU model with 5-cycle latency plus a queue-based scoreboard.
module tb_fpu_cmd_sequencer;
  localparam int DEPTH = 4;
  localparam int W     = 32;
  localparam int OPB   = 4;
  localparam int TAGB  = 2;
  localparam int CW    = $clog2(DEPTH+1);

  typedef struct packed {
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic [OPB-1:0]  op;
    logic [TAGB-1:0] tag;
  } cmd_t;

  typedef struct packed {
    logic [W-1:0]    data;
    logic [OPB-1:0]  op;
    logic [TAGB-1:0] tag;
  } rsp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [W-1:0]    cmd_a = '0, cmd_b = '0;
  logic [OPB-1:0]  cmd_op = '0;
  logic [TAGB-1:0] cmd_tag = '0;
  logic            fpu_start;
  logic [W-1:0]    fpu_a, fpu_b;
  logic [OPB-1:0]  fpu_op;
  logic [W-1:0]    fpu_res = '0;
  logic            fpu_ready = 1'b0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [W-1:0]    rsp_data;
  logic [OPB-1:0]  rsp_op;
  logic [CW-1:0]   count;
`ifdef FPU_SEQ_TAG_EN
  logic [TAGB-1:0] rsp_tag;
`endif

  int   checks = 0;
  int   errors = 0;
  cmd_t cmdq[$];
  rsp_t expq[$];
  bit   in_flight = 1'b0;

  fpu_cmd_sequencer #(.DEPTH(DEPTH), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_op    (cmd_op),
`ifdef FPU_SEQ_TAG_EN
    .cmd_tag   (cmd_tag),
    .rsp_tag   (rsp_tag),
`endif
    .fpu_start (fpu_start),
    .fpu_a     (fpu_a),
    .fpu_b     (fpu_b),
    .fpu_op    (fpu_op),
    .fpu_res   (fpu_res),
    .fpu_ready (fpu_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_op    (rsp_op),
    .count     (count)
  );

  always #5 clk = ~clk;

  // FPU: fpu_ready pulses 5 cycles after fpu_start with a ^ b; deliberately unaware of rst.
  task automatic fpu_model();
    int cd = 0;
    logic [W-1:0] res = '0;
    forever begin
      @(posedge clk); #1;
      fpu_ready = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          fpu_ready = 1'b1;
          fpu_res   = res;
        end
      end else if (fpu_start === 1'b1) begin
        cd  = 5;
        res = fpu_a ^ fpu_b;
      end
    end
  endtask

  // Scoreboard: samples just before each rising edge, predicts what that edge does.
  task automatic monitor();
    cmd_t c;
    rsp_t r;
    bit   acc;
    forever begin
      @(negedge clk); #2;
      if (rst) begin
        cmdq.delete();
        expq.delete();
        in_flight = 1'b0;
      end else begin
        checks++;
        if (count !== CW'(cmdq.size())) begin
          errors++; $display("FAIL mon_count got=%0d exp=%0d t=%0t", count, cmdq.size(), $time);
        end
        checks++;
        if (cmd_ready !== (cmdq.size() < DEPTH)) begin
          errors++; $display("FAIL mon_cmd_ready got=%b exp=%b t=%0t", cmd_ready, cmdq.size() < DEPTH, $time);
        end
        checks++;
        if (rsp_valid !== (expq.size() != 0)) begin
          errors++; $display("FAIL mon_rsp_valid got=%b exp=%b t=%0t", rsp_valid, expq.size() != 0, $time);
        end
        if (expq.size() != 0 && rsp_valid === 1'b1) begin
          checks++;
          if (rsp_data !== expq[0].data || rsp_op !== expq[0].op) begin
            errors++; $display("FAIL mon_rsp got=%h/%h exp=%h/%h t=%0t", rsp_data, rsp_op, expq[0].data, expq[0].op, $time);
          end
`ifdef FPU_SEQ_TAG_EN
          checks++;
          if (rsp_tag !== expq[0].tag) begin
            errors++; $display("FAIL mon_rsp_tag got=%0d exp=%0d t=%0t", rsp_tag, expq[0].tag, $time);
          end
`endif
        end
        if (fpu_start === 1'b1) begin
          checks++;
          if (in_flight || expq.size() != 0 || cmdq.size() == 0) begin
            errors++; $display("FAIL mon_overlap start while busy inflight=%b rsp=%0d q=%0d t=%0t", in_flight, expq.size(), cmdq.size(), $time);
          end else begin
            checks++;
            if (fpu_a !== cmdq[0].a || fpu_b !== cmdq[0].b || fpu_op !== cmdq[0].op) begin
              errors++; $display("FAIL mon_issue got=%h,%h,%h exp=%h,%h,%h t=%0t", fpu_a, fpu_b, fpu_op, cmdq[0].a, cmdq[0].b, cmdq[0].op, $time);
            end
          end
          in_flight = 1'b1;
        end
        acc = cmd_valid && (cmdq.size() < DEPTH);
        if (rsp_valid === 1'b1 && rsp_ready && expq.size() != 0) r = expq.pop_front();
        if (fpu_ready === 1'b1 && in_flight && cmdq.size() != 0) begin
          c      = cmdq.pop_front();
          r.data = c.a ^ c.b;
          r.op   = c.op;
          r.tag  = c.tag;
          expq.push_back(r);
          in_flight = 1'b0;
        end
        if (acc) begin
          c.a = cmd_a; c.b = cmd_b; c.op = cmd_op; c.tag = cmd_tag;
          cmdq.push_back(c);
        end
      end
    end
  endtask

  task automatic push_cmd(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [OPB-1:0] op, input logic [TAGB-1:0] tag);
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag;
      cmd_valid = 1'b1;
      if (cmd_ready === 1'b1) begin
        @(posedge clk); #1;
        done = 1'b1;
      end
    end
    cmd_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++; $display("FAIL push_timeout got=not_accepted exp=accepted");
    end
  endtask

  task automatic rand_push();
    push_cmd($urandom(), $urandom(), OPB'($urandom_range(0, 15)), TAGB'($urandom_range(0, 3)));
  endtask

  task automatic drain();
    bit done = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      done = (cmdq.size() == 0 && expq.size() == 0 && !in_flight);
    end
    checks++;
    if (!done) begin
      errors++; $display("FAIL drain_timeout got=q%0d/r%0d exp=0/0", cmdq.size(), expq.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (fpu_start !== 1'b0 || fpu_a !== '0 || fpu_b !== '0 || fpu_op !== '0) begin
      errors++; $display("FAIL reset_issue got=%b,%h,%h,%h exp=0", fpu_start, fpu_a, fpu_b, fpu_op);
    end
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_op !== '0) begin
      errors++; $display("FAIL reset_rsp got=%b,%h,%h exp=0", rsp_valid, rsp_data, rsp_op);
    end
    checks++;
    if (count !== '0) begin
      errors++; $display("FAIL reset_count got=%0d exp=0", count);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready);
    end
  endtask

  // Push at edge 0; cycle c is the interval sampled by edge c.
  task automatic test_latency();
    rsp_ready = 1'b1;
    push_cmd(32'h4080_0000, 32'h4040_0000, 4'h3, 2'd0);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      checks++;
      if (fpu_start !== (c == 2)) begin
        errors++; $display("FAIL latency_start cycle=%0d got=%b exp=%b", c, fpu_start, c == 2);
      end
      checks++;
      if (rsp_valid !== (c == 8)) begin
        errors++; $display("FAIL latency_rsp_valid cycle=%0d got=%b exp=%b", c, rsp_valid, c == 8);
      end
      if (c == 8) begin
        checks++;
        if (rsp_data !== 32'h00C0_0000 || rsp_op !== 4'h3) begin
          errors++; $display("FAIL latency_rsp_data got=%h/%h exp=00c00000/3", rsp_data, rsp_op);
        end
      end
    end
    drain();
  endtask

  task automatic test_full();
    bit seen = 1'b0;
    rsp_ready = 1'b0;
    repeat (4) rand_push();
    @(negedge clk);
    cmd_a = 32'hDEAD_BEEF; cmd_b = 32'h1234_5678; cmd_op = 4'hF; cmd_valid = 1'b1;
    repeat (2) begin
      checks++;
      if (cmd_ready !== 1'b0 || count !== CW'(4)) begin
        errors++; $display("FAIL full_block got=rdy%b/cnt%0d exp=rdy0/cnt4", cmd_ready, count);
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (fpu_ready === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!seen || count !== CW'(4)) begin
      errors++; $display("FAIL full_before_pop got=seen%b/cnt%0d exp=seen1/cnt4", seen, count);
    end
    @(negedge clk);
    checks++;
    if (count !== CW'(3) || rsp_valid !== 1'b1) begin
      errors++; $display("FAIL full_after_pop got=cnt%0d/vld%b exp=cnt3/vld1", count, rsp_valid);
    end
    drain();
  endtask

  task automatic test_hold();
    logic [W-1:0] hold_data;
    bit seen = 1'b0;
    rsp_ready = 1'b0;
    repeat (3) rand_push();
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = (rsp_valid === 1'b1);
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL hold_wait got=no_rsp exp=rsp_valid");
    end
    hold_data = rsp_data;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== hold_data || fpu_start !== 1'b0) begin
        errors++; $display("FAIL hold_stable got=%b,%h,%b exp=1,%h,0", rsp_valid, rsp_data, fpu_start, hold_data);
      end
    end
    checks++;
    if (count !== CW'(2)) begin
      errors++; $display("FAIL hold_count got=%0d exp=2", count);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (fpu_start !== 1'b1) begin
      errors++; $display("FAIL hold_reissue got=%b exp=1", fpu_start);
    end
    drain();
  endtask

  task automatic test_rst_wait();
    bit seen = 1'b0;
    rsp_ready = 1'b1;
    repeat (2) rand_push();
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = (fpu_start === 1'b1);
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL rstwait_start got=no_start exp=start");
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || count !== '0 || cmd_ready !== 1'b1 || fpu_start !== 1'b0) begin
        errors++; $display("FAIL rstwait_ignore got=vld%b/cnt%0d/rdy%b/st%b exp=0/0/1/0", rsp_valid, count, cmd_ready, fpu_start);
      end
    end
  endtask

  task automatic test_same_edge();
    bit seen = 1'b0;
    rsp_ready = 1'b1;
    repeat (2) rand_push();
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = (fpu_ready === 1'b1);
    end
    checks++;
    if (!seen || count !== CW'(2)) begin
      errors++; $display("FAIL same_edge_pre got=seen%b/cnt%0d exp=seen1/cnt2", seen, count);
    end
    cmd_a = $urandom(); cmd_b = $urandom(); cmd_op = 4'h9; cmd_tag = 2'd1;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checks++;
    if (count !== CW'(2)) begin
      errors++; $display("FAIL same_edge_count got=%0d exp=2", count);
    end
    // Nine in a row walks both pointers past the wrap; the scoreboard checks the data.
    repeat (9) rand_push();
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      cmd_valid = ($urandom_range(0, 2) != 0);
      cmd_a     = $urandom();
      cmd_b     = $urandom();
      cmd_op    = OPB'($urandom_range(0, 15));
      cmd_tag   = TAGB'($urandom_range(0, 3));
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    drain();
  endtask

`ifdef FPU_SEQ_TAG_EN
  task automatic test_tag();
    logic [TAGB-1:0] got [3];
    logic [TAGB-1:0] exp_tag [3];
    int n = 0;
    exp_tag[0] = 2'd3; exp_tag[1] = 2'd1; exp_tag[2] = 2'd2;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) push_cmd($urandom(), $urandom(), OPB'(i), exp_tag[i]);
    for (int i = 0; i < 100 && n < 3; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1 && rsp_ready) begin
        got[n] = rsp_tag;
        n++;
      end
    end
    checks++;
    if (n != 3) begin
      errors++; $display("FAIL tag_count got=%0d exp=3", n);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got[i] !== exp_tag[i]) begin
        errors++; $display("FAIL tag_seq idx=%0d got=%0d exp=%0d", i, got[i], exp_tag[i]);
      end
    end
    drain();
  endtask
`endif

  initial begin
    fork
      fpu_model();
      monitor();
    join_none
    test_reset();
    test_latency();
    test_full();
    test_hold();
    test_rst_wait();
    test_same_edge();
`ifdef FPU_SEQ_TAG_EN
    test_tag();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
